er1_sel_ctrl: RTL

ER1_SEL_CTRL -- requirements
Module: er1_sel_ctrl

---
 rtl/er1_sel_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/er1_sel_ctrl.sv
// ER1 JTAG select controller: scan register that picks which ER2 IP channel owns the JTAG chain.
// Latency: an accepted update is visible one JTCK cycle after the JUPDATE edge, or later if the current channel is busy.
// Backpressure: a select change waits in a pending slot while IP_BUSY of the applied channel is high, and the old enable stays asserted.
//
// Ports:
//   JTCK, JRSTN          clock, synchronous active-low reset
//   JTDI, JSHIFT, JCE1   scan data in, shift/capture select, ER1 instruction active
//   JUPDATE              update-DR strobe (ignored unless JCE1 is high)
//   JTDO1                ER1 scan out (sr[0])
//   ER2_TDO, ISPTRACY_ER2_TDO, JTDO2   channel serial outputs and the muxed result
//   IP_BUSY              per-channel busy, bit 0 = channel 0
//   IP_ENABLE            one-hot of the applied select, bit k-1 = channel k
//   ISPTRACY_ENABLE, CONTROL_DATAN, SWITCH_PENDING   status/control outputs
// Optional feature: define ER1_SEL_PARITY_EN to add an even-parity bit at the top of the scan register.

module er1_sel_ctrl #(
  parameter int N_IP  = 15,
  parameter int SEL_W = 4
) (
  input  logic            JTCK,
  input  logic            JRSTN,
  input  logic            JTDI,
  input  logic            JSHIFT,
  input  logic            JUPDATE,
  input  logic            JCE1,
  output logic            JTDO1,
  input  logic [N_IP-1:0] ER2_TDO,
  input  logic            ISPTRACY_ER2_TDO,
  input  logic [N_IP:0]   IP_BUSY,
  output logic            JTDO2,
  output logic [N_IP-1:0] IP_ENABLE,
  output logic            ISPTRACY_ENABLE,
  output logic            CONTROL_DATAN,
  output logic            SWITCH_PENDING
);

`ifdef ER1_SEL_PARITY_EN
  localparam int L = 6 + SEL_W;
`else
  localparam int L = 5 + SEL_W;
`endif

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N_IP);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [L-1:0]      sr_q, sr_d;
  logic [SEL_W-1:0]  sel_app_q, sel_app_d;
  logic [SEL_W-1:0]  sel_pend_q, sel_pend_d;
  logic              ctrl_q, ctrl_d;
  logic              ispt_q, ispt_d;
  logic              err_q, err_d;
  logic [N_IP-1:0]   en_q, en_d;

  logic              cap, shf, upd_req, upd, par_ok, range_err, new_err;
  logic [SEL_W-1:0]  req_raw, req;
  logic              busy_app;
  logic [L-1:0]      cap_val;

  assign cap     = JCE1 & ~JSHIFT;
  assign shf     = JCE1 & JSHIFT;
  assign upd_req = JUPDATE & JCE1;

  // Update fields always come from the pre-edge register contents.
  assign req_raw   = sr_q[5 +: SEL_W];
  assign range_err = (req_raw > MAX_SEL);
  assign req       = range_err ? '0 : req_raw;

`ifdef ER1_SEL_PARITY_EN
  // Top bit makes the parity over the control/select fields even.
  assign par_ok = (sr_q[L-1] == (^sr_q[L-2:3]));
`else
  assign par_ok = 1'b1;
`endif

  // A parity failure drops the whole update; an out-of-range select is still
  // applied (as channel 0) but flagged.
  assign upd     = upd_req & par_ok;
  assign new_err = (upd_req & ~par_ok) | (upd & range_err);

  // Busy bit of the currently applied channel and the JTDO2 mux; loops keep
  // the lookup in range for any select width.
  always_comb begin
    busy_app = IP_BUSY[0];
    JTDO2    = ISPTRACY_ER2_TDO;
    for (int k = 1; k <= N_IP; k++) begin
      if (sel_app_q == SEL_W'(k)) begin
        busy_app = IP_BUSY[k];
        JTDO2    = ER2_TDO[k-1];
      end
    end
  end

  always_comb begin
    cap_val           = '0;
    cap_val[0]        = err_q;
    cap_val[1]        = (state_q == ST_PEND);
    cap_val[2]        = 1'b1;
    cap_val[3]        = ctrl_q;
    cap_val[4]        = ispt_q;
    cap_val[5 +: SEL_W] = sel_app_q;
`ifdef ER1_SEL_PARITY_EN
    cap_val[L-1]      = ^{sel_app_q, ispt_q, ctrl_q};
`endif
  end

  always_comb begin
    sr_d       = sr_q;
    err_d      = err_q;
    ctrl_d     = ctrl_q;
    ispt_d     = ispt_q;
    sel_app_d  = sel_app_q;
    sel_pend_d = sel_pend_q;
    state_d    = state_q;
    en_d       = '0;

    if (cap) begin
      sr_d = cap_val;
    end else if (shf) begin
      sr_d = {JTDI, sr_q[L-1:1]};
    end

    // Read-clear on capture, but an error raised on the same edge survives.
    if (new_err) begin
      err_d = 1'b1;
    end else if (cap) begin
      err_d = 1'b0;
    end

    if (upd) begin
      ctrl_d = sr_q[3];
      ispt_d = sr_q[4];
    end

    case (state_q)
      ST_IDLE: begin
        if (upd && (req != sel_app_q)) begin
          if (!busy_app) begin
            sel_app_d = req;
          end else begin
            sel_pend_d = req;
            state_d    = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (upd && (req == sel_app_q)) begin
          // Re-requesting the applied channel cancels the switch.
          state_d = ST_IDLE;
        end else begin
          if (upd) begin
            sel_pend_d = req;
          end
          if (!busy_app) begin
            sel_app_d = upd ? req : sel_pend_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int k = 1; k <= N_IP; k++) begin
      en_d[k-1] = (sel_app_d == SEL_W'(k));
    end
  end

  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      sel_app_q  <= '0;
      sel_pend_q <= '0;
      ctrl_q     <= 1'b0;
      ispt_q     <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sel_app_q  <= sel_app_d;
      sel_pend_q <= sel_pend_d;
      ctrl_q     <= ctrl_d;
      ispt_q     <= ispt_d;
      err_q      <= err_d;
      en_q       <= en_d;
    end
  end

  assign JTDO1           = sr_q[0];
  assign IP_ENABLE       = en_q;
  assign ISPTRACY_ENABLE = ispt_q;
  assign CONTROL_DATAN   = ctrl_q;
  assign SWITCH_PENDING  = (state_q == ST_PEND);

endmodule
